// File: rtl/spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_pkg: shared widths, controller mode codes and baud divisor function.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package spi_pkg;

    localparam int SPPR_W = 3;
    localparam int SPR_W  = 3;
    localparam int DIV_W  = 12;

    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;
    localparam logic [1:0] SPI_STOP = 2'b10;

    function automatic logic [DIV_W-1:0] spi_divisor(
        input logic [SPPR_W-1:0] sppr,
        input logic [SPR_W-1:0]  spr
    );
        logic [DIV_W-1:0] base;
        logic [DIV_W-1:0] shamt;
        base  = DIV_W'(sppr) + DIV_W'(1);
        shamt = DIV_W'(spr) + DIV_W'(1);
        return base << shamt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_divcnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_clk_divcnt: half-period counter with terminal and pre-terminal decode. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_clk_divcnt
    import spi_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-2:0] last,
    output logic             terminal,
    output logic             pre_terminal
);

    localparam logic [DIV_W-2:0] C_CNT_ONE = {{(DIV_W-2){1'b0}}, 1'b1};

    logic [DIV_W-2:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!en || terminal) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
        end
    end

    // >= so a divisor shrunk mid-transfer wraps instead of running to overflow
    assign terminal     = (r_cnt >= last);
    assign pre_terminal = (last == '0) ? terminal : (r_cnt == (last - C_CNT_ONE));

endmodule
`default_nettype wire

// File: rtl/spi_baud_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spi_baud_generator: PCLK -> sclk divider with edge-anticipation strobes.   |
// | Optional bit/byte counter enabled by macro SPI_BAUD_BITCNT_EN.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module spi_baud_generator
    import spi_pkg::*;
(
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              ss,
    input  logic [1:0]        spi_mode,
    input  logic              spiswai,
    input  logic [SPPR_W-1:0] sppr,
    input  logic [SPR_W-1:0]  spr,
    input  logic              cpol,
    output logic              sclk,
    output logic              flag_low,
    output logic              flag_high,
    output logic              flags_low,
    output logic              flags_high,
    output logic [DIV_W-1:0]  baudratedivisor
`ifdef SPI_BAUD_BITCNT_EN
    ,
    output logic [2:0]        bit_cnt,
    output logic              byte_done
`endif
);

    localparam logic [DIV_W-2:0] C_CNT_ONE = {{(DIV_W-2){1'b0}}, 1'b1};

    logic             w_run;
    logic             w_live;
    logic             r_primed;
    logic             r_sclk;
    logic             w_term;
    logic             w_pre;
    logic [DIV_W-2:0] w_half;
    logic [DIV_W-2:0] w_half_m1;

    assign baudratedivisor = spi_divisor(sppr, spr);
    assign w_half          = baudratedivisor[DIV_W-1:1];
    assign w_half_m1       = (w_half == '0) ? '0 : (w_half - C_CNT_ONE);

    assign w_run = !ss && ((spi_mode == SPI_RUN) || ((spi_mode == SPI_WAIT) && !spiswai));

    // Holds the divider idle for one edge after reset so sclk settles at cpol first
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_primed <= 1'b0;
        end else begin
            r_primed <= 1'b1;
        end
    end

    assign w_live = w_run && r_primed;

    spi_clk_divcnt u_divcnt (
        .clk          (PCLK),
        .rst_n        (PRESETn),
        .en           (w_live),
        .last         (w_half_m1),
        .terminal     (w_term),
        .pre_terminal (w_pre)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_sclk <= 1'b0;
        end else if (!w_live) begin
            r_sclk <= cpol;
        end else if (w_term) begin
            r_sclk <= ~r_sclk;
        end
    end

    assign sclk = r_sclk;

    // Strobes decode the registered counter/sclk; a dropping run masks them at once
    assign flag_low   = w_live && w_term && !r_sclk;
    assign flag_high  = w_live && w_term &&  r_sclk;
    assign flags_low  = w_live && w_pre  && !r_sclk;
    assign flags_high = w_live && w_pre  &&  r_sclk;

`ifdef SPI_BAUD_BITCNT_EN
    logic r_idle;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_idle    <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (!w_live) begin
                r_idle  <= cpol;
                bit_cnt <= 3'd0;
            end else if (w_term && (r_sclk != r_idle)) begin
                bit_cnt   <= bit_cnt + 3'd1;
                byte_done <= (bit_cnt == 3'd7);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_baud_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spi_baud_generator: directed + random stimulus against a cycle model.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_spi_baud_generator;
    import spi_pkg::*;

    logic              PCLK     = 1'b0;
    logic              PRESETn  = 1'b0;
    logic              ss       = 1'b1;
    logic [1:0]        spi_mode = SPI_RUN;
    logic              spiswai  = 1'b0;
    logic [SPPR_W-1:0] sppr     = '0;
    logic [SPR_W-1:0]  spr      = '0;
    logic              cpol     = 1'b0;
    logic              sclk, flag_low, flag_high, flags_low, flags_high;
    logic [DIV_W-1:0]  baudratedivisor;
`ifdef SPI_BAUD_BITCNT_EN
    logic [2:0]        bit_cnt;
    logic              byte_done;
`endif

    spi_baud_generator dut (
        .PCLK            (PCLK),
        .PRESETn         (PRESETn),
        .ss              (ss),
        .spi_mode        (spi_mode),
        .spiswai         (spiswai),
        .sppr            (sppr),
        .spr             (spr),
        .cpol            (cpol),
        .sclk            (sclk),
        .flag_low        (flag_low),
        .flag_high       (flag_high),
        .flags_low       (flags_low),
        .flags_high      (flags_high),
        .baudratedivisor (baudratedivisor)
`ifdef SPI_BAUD_BITCNT_EN
        ,
        .bit_cnt         (bit_cnt),
        .byte_done       (byte_done)
`endif
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: m_t = PCLK cycles since the current run segment began,
    // m_seg = sclk level the segment started from, m_half = its half period.
    int m_t      = 0;
    int m_half   = 1;
    int prev_half = 1;
    bit m_seg    = 1'b0;
    bit m_primed = 1'b0;
    bit m_live   = 1'b0;
    bit prev_live = 1'b0;
    bit prev_cpol = 1'b0;
    int byte_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_div(input int pp, input int r);
        return (pp + 1) * (1 << (r + 1));
    endfunction

    function automatic int exp_half(input int d);
        return (d / 2 < 1) ? 1 : d / 2;
    endfunction

    function automatic bit spec_run(input logic s, input logic [1:0] m, input logic w);
        return (s == 1'b0) && ((m == 2'b00) || ((m == 2'b01) && (w == 1'b0)));
    endfunction

    function automatic void update_live();
        m_live    = (PRESETn === 1'b1) && m_primed && spec_run(ss, spi_mode, spiswai);
        prev_live = m_live;
        prev_cpol = cpol;
        prev_half = exp_half(exp_div(int'(sppr), int'(spr)));
    endfunction

    function automatic void model_edge();
        if (PRESETn !== 1'b1) begin
            m_t = 0; m_seg = 1'b0; m_primed = 1'b0;
        end else begin
            if (prev_live) begin
                m_t++;
            end else begin
                m_t    = 0;
                m_seg  = prev_cpol;
                m_half = prev_half;
            end
            m_primed = 1'b1;
        end
    endfunction

    task automatic check_outputs();
        bit s, fl, fs;
        int r;
`ifdef SPI_BAUD_BITCNT_EN
        int rb, rb_prev;
`endif
        check("divisor", 32'(baudratedivisor), exp_div(int'(sppr), int'(spr)));
        s = (PRESETn !== 1'b1) ? 1'b0 : (m_seg ^ (((m_t / m_half) % 2) != 0));
        fl = 1'b0;
        fs = 1'b0;
        if (m_live) begin
            r  = m_t % m_half;
            fl = (r == m_half - 1);
            fs = (m_half == 1) ? fl : (r == m_half - 2);
        end
        check("sclk",       32'(sclk),       32'(s));
        check("flag_low",   32'(flag_low),   32'(fl && !s));
        check("flag_high",  32'(flag_high),  32'(fl &&  s));
        check("flags_low",  32'(flags_low),  32'(fs && !s));
        check("flags_high", 32'(flags_high), 32'(fs &&  s));
`ifdef SPI_BAUD_BITCNT_EN
        rb      = (m_t / m_half) / 2;
        rb_prev = (m_t == 0) ? 0 : ((m_t - 1) / m_half) / 2;
        check("bit_cnt",   32'(bit_cnt),   rb % 8);
        check("byte_done", 32'(byte_done), 32'((m_t > 0) && (rb != rb_prev) && (rb % 8 == 0)));
        if (byte_done === 1'b1) byte_pulses++;
`endif
    endtask

    task automatic step(input logic n_ss, input logic [1:0] n_mode, input logic n_swai,
                        input logic [SPPR_W-1:0] n_pp, input logic [SPR_W-1:0] n_r, input logic n_cpol);
        @(posedge PCLK);
        model_edge();
        #1;
        ss = n_ss; spi_mode = n_mode; spiswai = n_swai; sppr = n_pp; spr = n_r; cpol = n_cpol;
        update_live();
        #2;
        check_outputs();
    endtask

    task automatic hold(input int n, input logic n_ss, input logic [1:0] n_mode, input logic n_swai);
        for (int i = 0; i < n; i++) step(n_ss, n_mode, n_swai, sppr, spr, cpol);
    endtask

    task automatic async_reset();
        @(posedge PCLK);
        model_edge();
        #2;
        PRESETn = 1'b0;
        m_primed = 1'b0; m_t = 0; m_seg = 1'b0;
        update_live();
        #1;
        check_outputs();
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK);
            model_edge();
            #3;
            check_outputs();
        end
        @(posedge PCLK);
        model_edge();
        #2;
        PRESETn = 1'b1;
        update_live();
        #1;
        check_outputs();
    endtask

    initial begin
        logic n_ss, n_swai, n_cpol;
        logic [1:0] n_mode;
        logic [SPPR_W-1:0] n_pp;
        logic [SPR_W-1:0] n_r;
        int pulses0;

        update_live();
        repeat (2) @(posedge PCLK);
        #3;
        check_outputs();
        @(posedge PCLK);
        model_edge();
        #1;
        PRESETn = 1'b1;
        update_live();
        #2;
        check_outputs();

        // divisor 2, cpol 0
        step(1'b1, SPI_RUN, 1'b0, 3'd0, 3'd0, 1'b0);
        hold(20, 1'b0, SPI_RUN, 1'b0);
        hold(3, 1'b1, SPI_RUN, 1'b0);

        // divisor 12, cpol 1, then a drop exactly on a flag_high cycle with cpol 0
        step(1'b1, SPI_RUN, 1'b0, 3'd2, 3'd1, 1'b1);
        hold(40, 1'b0, SPI_RUN, 1'b0);
        step(1'b1, SPI_RUN, 1'b0, 3'd2, 3'd1, 1'b0);
        step(1'b1, SPI_RUN, 1'b0, 3'd2, 3'd1, 1'b0);
        hold(11, 1'b0, SPI_RUN, 1'b0);
        hold(3, 1'b1, SPI_RUN, 1'b0);

        // WAIT with and without spiswai, then STOP
        hold(10, 1'b0, SPI_RUN, 1'b0);
        hold(5, 1'b0, SPI_WAIT, 1'b1);
        hold(20, 1'b0, SPI_WAIT, 1'b0);
        hold(3, 1'b0, SPI_STOP, 1'b0);
        hold(5, 1'b0, SPI_RUN, 1'b0);

        // divisor 4 for 16 sclk periods
        step(1'b1, SPI_RUN, 1'b0, 3'd0, 3'd1, 1'b0);
        step(1'b1, SPI_RUN, 1'b0, 3'd0, 3'd1, 1'b0);
        pulses0 = byte_pulses;
        hold(65, 1'b0, SPI_RUN, 1'b0);
        hold(2, 1'b1, SPI_RUN, 1'b0);
`ifdef SPI_BAUD_BITCNT_EN
        check("byte_done_count", byte_pulses - pulses0, 2);
`endif

        // randomized traffic; divisor/rate only change while ss is high
        for (int i = 0; i < 3000; i++) begin
            n_ss = ss; n_mode = spi_mode; n_swai = spiswai; n_cpol = cpol; n_pp = sppr; n_r = spr;
            if ($urandom_range(0, ss ? 7 : 39) == 0) n_ss = ~ss;
            if ($urandom_range(0, 49) == 0) n_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) n_swai = ~spiswai;
            if ($urandom_range(0, 59) == 0) n_cpol = ~cpol;
            if (n_ss && $urandom_range(0, 3) == 0) begin
                n_pp = 3'($urandom_range(0, 7));
                n_r  = 3'($urandom_range(0, 2));
            end
            step(n_ss, n_mode, n_swai, n_pp, n_r, n_cpol);
        end

        // maximum divisor, async reset mid-transfer
        step(1'b1, SPI_RUN, 1'b0, 3'd7, 3'd7, 1'b1);
        step(1'b1, SPI_RUN, 1'b0, 3'd7, 3'd7, 1'b1);
        hold(1500, 1'b0, SPI_RUN, 1'b0);
        async_reset();
        hold(1100, 1'b0, SPI_RUN, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
